branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 110 +++++++++++
 tb/tb_branch_predictor.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit counters plus a tagged BTB sharing one index.
// Define BP_STATS_EN to build the saturating branch and mispredict counters.
module branch_predictor #(
  parameter int unsigned INDEX_WIDTH = 6
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] pc_f_i,
  input  logic [31:0] pc_e_i,
  input  logic [31:0] pc_target_e_i,
  input  logic [1:0]  branch_op_e_i,
  input  logic        pc_src_res_e_i,
  input  logic        pc_src_pred_e_i,
  input  logic        target_match_e_i,
  input  logic        stall_e_i,
  output logic        pc_src_pred_f_o,
  output logic [31:0] pred_pc_target_f_o,
  output logic        mispredict_e_o,
  output logic [31:0] branch_count_o,
  output logic [31:0] mispredict_count_o
);

  localparam int unsigned Entries = 1 << INDEX_WIDTH;
  localparam int unsigned TagW    = 32 - INDEX_WIDTH - 2;

  logic [1:0]           cnt_q    [Entries];
  logic [TagW-1:0]      tag_q    [Entries];
  logic [31:0]          target_q [Entries];
  logic [Entries-1:0]   valid_q;
  logic [Entries-1:0]   jump_q;

  logic [INDEX_WIDTH-1:0] idx_f, idx_e;
  logic [TagW-1:0]        tag_f, tag_e;
  logic                   hit_f, is_jump_e, is_cond_e, update_e;
  logic [1:0]             cnt_d;
  logic                   unused_pc_lsbs;

  assign idx_f = pc_f_i[INDEX_WIDTH+1:2];
  assign tag_f = pc_f_i[31:INDEX_WIDTH+2];
  assign idx_e = pc_e_i[INDEX_WIDTH+1:2];
  assign tag_e = pc_e_i[31:INDEX_WIDTH+2];
  assign unused_pc_lsbs = ^{pc_f_i[1:0], pc_e_i[1:0]};

  // Lookup reads the registered arrays, so a same-cycle write is seen only next cycle.
  assign hit_f              = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pc_src_pred_f_o    = hit_f && (jump_q[idx_f] || cnt_q[idx_f][1]);
  assign pred_pc_target_f_o = hit_f ? target_q[idx_f] : pc_f_i + 32'd4;

  assign is_jump_e = (branch_op_e_i == 2'b01);
  assign is_cond_e = (branch_op_e_i == 2'b10);
  assign update_e  = (is_jump_e || is_cond_e) && !stall_e_i;

  assign mispredict_e_o = (is_jump_e || is_cond_e) &&
                          ((pc_src_pred_e_i != pc_src_res_e_i) ||
                           (pc_src_res_e_i && !target_match_e_i));

  always_comb begin
    cnt_d = cnt_q[idx_e];
    if (pc_src_res_e_i) begin
      if (cnt_q[idx_e] != 2'b11) cnt_d = cnt_q[idx_e] + 2'b01;
    end else begin
      if (cnt_q[idx_e] != 2'b00) cnt_d = cnt_q[idx_e] - 2'b01;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= '0;
      jump_q  <= '0;
      for (int i = 0; i < Entries; i++) cnt_q[i] <= 2'b01;
    end else if (update_e) begin
      if (is_cond_e) cnt_q[idx_e] <= cnt_d;
      if (pc_src_res_e_i) begin
        valid_q[idx_e] <= 1'b1;
        jump_q[idx_e]  <= is_jump_e;
      end
    end
  end

  // Tag and target need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk_i) begin
    if (update_e && pc_src_res_e_i) begin
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= pc_target_e_i;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branch_cnt_q, mispredict_cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (update_e) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict_e_o && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = mispredict_cnt_q;
`else
  assign branch_count_o     = '0;
  assign mispredict_count_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [31:0] pc_f_i, pc_e_i, pc_target_e_i;
  logic [1:0]  branch_op_e_i;
  logic        pc_src_res_e_i, pc_src_pred_e_i, target_match_e_i, stall_e_i;
  logic        pc_src_pred_f_o, mispredict_e_o;
  logic [31:0] pred_pc_target_f_o, branch_count_o, mispredict_count_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk_i = ~clk_i;

  branch_predictor #(.INDEX_WIDTH(6)) dut (
    .clk_i              (clk_i),
    .reset_n_i          (reset_n_i),
    .pc_f_i             (pc_f_i),
    .pc_e_i             (pc_e_i),
    .pc_target_e_i      (pc_target_e_i),
    .branch_op_e_i      (branch_op_e_i),
    .pc_src_res_e_i     (pc_src_res_e_i),
    .pc_src_pred_e_i    (pc_src_pred_e_i),
    .target_match_e_i   (target_match_e_i),
    .stall_e_i          (stall_e_i),
    .pc_src_pred_f_o    (pc_src_pred_f_o),
    .pred_pc_target_f_o (pred_pc_target_f_o),
    .mispredict_e_o     (mispredict_e_o),
    .branch_count_o     (branch_count_o),
    .mispredict_count_o (mispredict_count_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_taken,
                        input logic [31:0] exp_tgt);
    pc_f_i = pc;
    #1;
    check_eq({tag, "_pred"}, {31'd0, pc_src_pred_f_o}, {31'd0, exp_taken});
    check_eq({tag, "_tgt"}, pred_pc_target_f_o, exp_tgt);
  endtask

  // Drive one Execute-stage update for one clock; mispredict checked before the edge.
  task automatic upd(input string tag, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic [1:0] op, input logic res, input logic pred, input logic match,
                     input logic stall, input logic exp_mis);
    @(negedge clk_i);
    pc_e_i = pc; pc_target_e_i = tgt; branch_op_e_i = op;
    pc_src_res_e_i = res; pc_src_pred_e_i = pred; target_match_e_i = match; stall_e_i = stall;
    #1;
    check_eq({tag, "_mis"}, {31'd0, mispredict_e_o}, {31'd0, exp_mis});
    @(posedge clk_i);
    #1;
    branch_op_e_i = 2'b00; stall_e_i = 1'b0;
  endtask

  task automatic check_counts(input string tag, input logic [31:0] b, input logic [31:0] m);
`ifdef BP_STATS_EN
    check_eq({tag, "_bcnt"}, branch_count_o, b);
    check_eq({tag, "_mcnt"}, mispredict_count_o, m);
`else
    check_eq({tag, "_bcnt"}, branch_count_o, 32'd0);
    check_eq({tag, "_mcnt"}, mispredict_count_o, 32'd0);
    if (b == 32'hDEAD_BEEF) $display("unused %0d", m);
`endif
  endtask

  initial begin
    pc_f_i = 32'h100; pc_e_i = '0; pc_target_e_i = '0; branch_op_e_i = 2'b00;
    pc_src_res_e_i = 0; pc_src_pred_e_i = 0; target_match_e_i = 0; stall_e_i = 0;
    reset_n_i = 1'b0;
    #12;
    lookup("rst", 32'h100, 1'b0, 32'h104);
    check_counts("rst", 32'd0, 32'd0);
    @(negedge clk_i); reset_n_i = 1'b1;

    lookup("post_rst", 32'h100, 1'b0, 32'h104);

    // Same-cycle read of the index being written still sees the old contents.
    pc_f_i = 32'h100;
    @(negedge clk_i);
    pc_e_i = 32'h100; pc_target_e_i = 32'h80; branch_op_e_i = 2'b10;
    pc_src_res_e_i = 1; pc_src_pred_e_i = 0; target_match_e_i = 0;
    #1;
    check_eq("t1_mis", {31'd0, mispredict_e_o}, 32'd1);
    check_eq("t1_same_cycle_pred", {31'd0, pc_src_pred_f_o}, 32'd0);
    check_eq("t1_same_cycle_tgt", pred_pc_target_f_o, 32'h104);
    @(posedge clk_i); #1; branch_op_e_i = 2'b00;
    lookup("t1_after", 32'h100, 1'b1, 32'h80);           // counter 2
    upd("t2", 32'h100, 32'h80, 2'b10, 1, 0, 0, 0, 1'b1); // counter 3
    lookup("t2_after", 32'h100, 1'b1, 32'h80);
    check_counts("t2", 32'd2, 32'd2);

    // Saturation: taken at 3 stays 3, then two not-taken leave counter at 1.
    upd("sat", 32'h100, 32'h80, 2'b10, 1, 1, 1, 0, 1'b0);
    upd("nt1", 32'h100, 32'h0, 2'b10, 0, 1, 0, 0, 1'b1);
    lookup("nt1_after", 32'h100, 1'b1, 32'h80);
    upd("nt2", 32'h100, 32'h0, 2'b10, 0, 1, 0, 0, 1'b1);
    lookup("nt2_after", 32'h100, 1'b0, 32'h80);          // hit, weakly not taken
    upd("tk_wrongtgt", 32'h100, 32'h80, 2'b10, 1, 1, 0, 0, 1'b1); // counter 2
    lookup("tk_after", 32'h100, 1'b1, 32'h80);

    // Stalled update: no state change, mispredict still combinational.
    upd("stall", 32'h100, 32'h0, 2'b10, 0, 1, 0, 1, 1'b1);
    upd("stall2", 32'h100, 32'h0, 2'b10, 0, 1, 0, 1, 1'b1);
    lookup("stall_after", 32'h100, 1'b1, 32'h80);
    check_counts("stall", 32'd6, 32'd5);

    // op 11 is not a branch: no mispredict and no update.
    upd("op11", 32'h100, 32'h0, 2'b11, 0, 1, 0, 0, 1'b0);
    upd("op00", 32'h100, 32'h0, 2'b00, 1, 0, 0, 0, 1'b0);
    lookup("op11_after", 32'h100, 1'b1, 32'h80);

    lookup("alias", 32'h200, 1'b0, 32'h204);

    // Jump at 0x200 replaces the aliased entry; not-taken updates keep the jump flag.
    upd("jmp", 32'h200, 32'h400, 2'b01, 1, 0, 0, 0, 1'b1);
    lookup("jmp_after", 32'h200, 1'b1, 32'h400);
    lookup("evicted", 32'h100, 1'b0, 32'h104);
    for (int i = 0; i < 3; i++) upd("jmp_nt", 32'h200, 32'h0, 2'b10, 0, 1, 0, 0, 1'b1);
    lookup("jmp_nt_after", 32'h200, 1'b1, 32'h400);
    check_counts("jmp", 32'd10, 32'd9);

    // Reset pulse clears tables and counts.
    @(negedge clk_i); reset_n_i = 1'b0;
    #1;
    lookup("rst2", 32'h200, 1'b0, 32'h204);
    check_counts("rst2", 32'd0, 32'd0);
    @(negedge clk_i); reset_n_i = 1'b1;

    // Five updates, two mispredicts.
    upd("s1", 32'h300, 32'h500, 2'b10, 1, 0, 0, 0, 1'b1);
    upd("s2", 32'h300, 32'h500, 2'b10, 1, 1, 1, 0, 1'b0);
    upd("s3", 32'h300, 32'h0,   2'b10, 0, 0, 0, 0, 1'b0);
    upd("s4", 32'h300, 32'h600, 2'b01, 1, 1, 0, 0, 1'b1);
    upd("s5", 32'h300, 32'h0,   2'b10, 0, 0, 0, 0, 1'b0);
    check_counts("stats", 32'd5, 32'd2);
    lookup("stats_tbl", 32'h300, 1'b1, 32'h600);

    // Reset during an update discards it.
    @(negedge clk_i); reset_n_i = 1'b0;
    @(negedge clk_i);
    pc_e_i = 32'h104; pc_target_e_i = 32'h900; branch_op_e_i = 2'b01;
    pc_src_res_e_i = 1; pc_src_pred_e_i = 0; target_match_e_i = 0;
    @(posedge clk_i); #1;
    reset_n_i = 1'b1; branch_op_e_i = 2'b00;
    lookup("rst_mid", 32'h104, 1'b0, 32'h108);
    check_counts("rst_mid", 32'd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
